// File: rtl/control_sequencer_if.sv
// Instruction-fetch handshake between the control sequencer (master) and
// instruction memory (slave).
interface control_sequencer_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_req;
  logic [63:0] pc;

  modport master (input instr, input instr_valid, output instr_req, output pc);
  modport slave  (output instr, output instr_valid, input instr_req, input pc);
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetches a 32-bit word, decodes it and
// drives ALU, register-file and RAM controls for one or two execute cycles.
//
// state | meaning
// FETCH | request instruction, latch IR when instr_valid
// EXEC  | decode IR; ALU/MOV ops retire here, LDR/STR move on to MEM
// MEM   | RAM access for LDR/STR, then retire
// HALT  | parked until reset, halted=1
module control_sequencer #(
  parameter logic [63:0] PC_RESET = 64'd0,
  parameter logic [1:0]  RAM_SIZE = 2'b11
) (
  input  logic                       clock,
  input  logic                       reset,
  control_sequencer_if.master        ibus,
  output logic [63:0]                k,
  output logic [4:0]                 FS,
  output logic                       C0,
  output logic [4:0]                 SA,
  output logic [4:0]                 SB,
  output logic [4:0]                 DA,
  output logic                       B_Sel,
  output logic                       EN_B,
  output logic                       EN_ALU,
  output logic                       EN_ADDR_ALU,
  output logic                       w_reg,
  output logic                       ram_cs,
  output logic                       ram_write_en,
  output logic                       ram_read_en,
  output logic [1:0]                 ramOutsize,
  output logic                       halted,
  output logic                       illegal
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALUR = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_ORI  = 4'd3;
  localparam logic [3:0] OP_LDR  = 4'd4;
  localparam logic [3:0] OP_STR  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_OR  = 5'b01100;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        started_q;
  logic        req_c;
  logic [3:0]  op;
  logic [63:0] pc_inc;

  assign op         = ir_q[31:28];
  assign DA         = ir_q[27:23];
  assign SA         = ir_q[22:18];
  assign SB         = ir_q[17:13];
  assign k          = {51'd0, ir_q[12:0]};
  assign pc_inc     = pc_q + 64'd4;
  assign ibus.pc    = pc_q;
  assign ibus.instr_req = req_c;
  assign ramOutsize = RAM_SIZE;

  // started_q holds off the first fetch until an edge has seen reset released
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= 32'd0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    req_c        = 1'b0;
    FS           = 5'd0;
    C0           = 1'b0;
    B_Sel        = 1'b0;
    EN_B         = 1'b0;
    EN_ALU       = 1'b0;
    EN_ADDR_ALU  = 1'b0;
    w_reg        = 1'b0;
    ram_cs       = 1'b0;
    ram_write_en = 1'b0;
    ram_read_en  = 1'b0;
    halted       = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      FETCH: begin
        if (started_q) begin
          req_c = 1'b1;
          if (ibus.instr_valid) begin
            ir_d    = ibus.instr;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        pc_d    = pc_inc;
        state_d = FETCH;
        case (op)
          OP_NOP: ;
          OP_ALUR: begin
            EN_ALU = 1'b1;
            w_reg  = 1'b1;
            FS     = ir_q[12:8];
            C0     = ir_q[7];
          end
          OP_ADDI: begin
            EN_ALU = 1'b1;
            w_reg  = 1'b1;
            B_Sel  = 1'b1;
            FS     = FS_ADD;
          end
          OP_ORI: begin
            EN_ALU = 1'b1;
            w_reg  = 1'b1;
            B_Sel  = 1'b1;
            FS     = FS_OR;
          end
          OP_MOV: begin
            EN_B  = 1'b1;
            w_reg = 1'b1;
          end
          OP_LDR, OP_STR: begin
            FS          = FS_ADD;
            B_Sel       = 1'b1;
            EN_ADDR_ALU = 1'b1;
            ram_cs      = 1'b1;
            pc_d        = pc_q;
            state_d     = MEM;
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = HALT;
          end
          default: illegal = 1'b1;
        endcase
      end
      MEM: begin
        FS          = FS_ADD;
        B_Sel       = 1'b1;
        EN_ADDR_ALU = 1'b1;
        ram_cs      = 1'b1;
        if (op == OP_LDR) begin
          ram_read_en = 1'b1;
          w_reg       = 1'b1;
        end else begin
          EN_B         = 1'b1;
          ram_write_en = 1'b1;
        end
        pc_d    = pc_inc;
        state_d = FETCH;
      end
      HALT: halted = 1'b1;
      default: state_d = FETCH;
    endcase

    // Outputs stay quiet for as long as reset is held, whatever the state
    if (!reset) begin
      req_c        = 1'b0;
      FS           = 5'd0;
      C0           = 1'b0;
      B_Sel        = 1'b0;
      EN_B         = 1'b0;
      EN_ALU       = 1'b0;
      EN_ADDR_ALU  = 1'b0;
      w_reg        = 1'b0;
      ram_cs       = 1'b0;
      ram_write_en = 1'b0;
      ram_read_en  = 1'b0;
      halted       = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule
